multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 30 +++
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and its
// instruction/data memories.
//   imem_req   : instruction fetch request (controller -> memory)
//   imem_ready : instruction fetch accept/complete strobe (memory -> controller)
//   dmem_read  : data load request (controller -> memory)
//   dmem_write : data store request (controller -> memory)
//   dmem_ready : data access accept/complete strobe (memory -> controller)
interface multicycle_controller_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_read;
    logic dmem_write;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_read,
        output dmem_write,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_read,
        input  dmem_write,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV-subset control FSM: fetch, decode, execute, memory and
// write-back sequencing with memory wait timeout and retired-instruction count.
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset
//   run           : permits instruction sequencing (sampled in IDLE and at retire)
//   opcode        : instruction[6:0], sampled in DECODE
//   branch_cond   : branch taken flag, used in EXEC of a branch
//   mem           : memory handshake (master side)
//   ir_write      : instruction register load strobe
//   pc_write/src  : PC update strobe / select (0 = PC+4, 1 = branch target)
//   reg_write, alu_src, mem_to_reg, alu_op : datapath controls
//   illegal_instr : pulses in DECODE for an unknown opcode
//   timeout       : held in HALT after a memory wait timeout
//   state         : current FSM state encoding
//   instr_count   : retired instruction count (wraps)
// Strobes are decoded from the registered state (and the ready strobes), so
// they go to 0 as soon as reset forces the state to IDLE.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [6:0]              opcode,
    input  logic                    branch_cond,
    multicycle_controller_if.master mem,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    reg_write,
    output logic                    alu_src,
    output logic                    mem_to_reg,
    output logic [1:0]              alu_op,
    output logic                    illegal_instr,
    output logic                    timeout,
    output logic [2:0]              state,
    output logic [31:0]             instr_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_LDST   = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RI     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_ILL
    } cls_e;

    state_e            state_q, state_n, retire_state;
    cls_e              cls_q, cls_n;
    logic [WAIT_W-1:0] wait_q, wait_n;
    logic              armed_q;
    logic              retire;
    logic              at_limit;
    logic              imem_req_c, dmem_read_c, dmem_write_c;

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            OP_R:      classify = C_R;
            OP_I:      classify = C_I;
            OP_LOAD:   classify = C_LOAD;
            OP_STORE:  classify = C_STORE;
            OP_BRANCH: classify = C_BRANCH;
            default:   classify = C_ILL;
        endcase
    endfunction

    assign state          = state_q;
    assign mem.imem_req   = imem_req_c;
    assign mem.dmem_read  = dmem_read_c;
    assign mem.dmem_write = dmem_write_c;

    // Last permitted wait cycle: staying un-ready here means the counter hits MEM_TIMEOUT.
    assign at_limit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    // State, decoded class, wait counter, retire counter and post-reset arming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cls_q       <= C_ILL;
            wait_q      <= '0;
            instr_count <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q <= state_n;
            cls_q   <= cls_n;
            wait_q  <= wait_n;
            armed_q <= 1'b1;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_n       = state_q;
        cls_n         = cls_q;
        wait_n        = wait_q;
        retire        = 1'b0;
        retire_state  = run ? S_FETCH : S_IDLE;
        imem_req_c    = 1'b0;
        dmem_read_c   = 1'b0;
        dmem_write_c  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;
        timeout       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // armed_q keeps the first edge after reset release in IDLE.
                if (armed_q && run) begin
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_write = 1'b1;
                    state_n  = S_DECODE;
                end else if (at_limit) begin
                    state_n = S_HALT;
                end
            end
            S_DECODE: begin
                cls_n = classify(opcode);
                if (cls_n == C_ILL) begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                    retire        = 1'b1;
                    state_n       = retire_state;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = ALU_RI;
                        state_n = S_WB;
                    end
                    C_I: begin
                        alu_op  = ALU_RI;
                        alu_src = 1'b1;
                        state_n = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_op  = ALU_LDST;
                        alu_src = 1'b1;
                        state_n = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op   = ALU_BRANCH;
                        pc_write = 1'b1;
                        pc_src   = branch_cond;
                        retire   = 1'b1;
                        state_n  = retire_state;
                    end
                    default: state_n = S_IDLE;
                endcase
            end
            S_MEM: begin
                alu_op       = ALU_LDST;
                alu_src      = 1'b1;
                dmem_read_c  = (cls_q == C_LOAD);
                dmem_write_c = (cls_q == C_STORE);
                if (mem.dmem_ready) begin
                    if (cls_q == C_LOAD) begin
                        state_n = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_n  = retire_state;
                    end
                end else if (at_limit) begin
                    state_n = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (cls_q == C_LOAD);
                retire     = 1'b1;
                state_n    = retire_state;
            end
            S_HALT: begin
                timeout = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Any state change restarts the count; staying in FETCH/MEM means ready was 0.
        if (state_n != state_q) begin
            wait_n = '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            wait_n = wait_q + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller. Each cycle drives inputs
// just after the falling edge and compares state, strobes and instr_count
// 1 ns later against hand-computed tables.
module tb_multicycle_controller;

    typedef struct packed {
        logic        run;
        logic        ir;
        logic        dr;
        logic [6:0]  op;
        logic        bc;
        logic [2:0]  st;
        logic [12:0] o;
        logic [31:0] cnt;
    } vec_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {imem_req,ir_write}_{pc_write,pc_src}_{dmem_read,dmem_write}_
    // {reg_write,alu_src,mem_to_reg}_{alu_op}_{illegal_instr,timeout}
    localparam logic [12:0] O_NONE   = 13'b00_00_00_000_00_00;
    localparam logic [12:0] O_F_NR   = 13'b10_00_00_000_00_00;
    localparam logic [12:0] O_F_R    = 13'b11_00_00_000_00_00;
    localparam logic [12:0] O_EX_R   = 13'b00_00_00_000_10_00;
    localparam logic [12:0] O_EX_I   = 13'b00_00_00_010_10_00;
    localparam logic [12:0] O_EX_LS  = 13'b00_00_00_010_00_00;
    localparam logic [12:0] O_MEM_LD = 13'b00_00_10_010_00_00;
    localparam logic [12:0] O_MEM_ST = 13'b00_00_01_010_00_00;
    localparam logic [12:0] O_ST_END = 13'b00_10_01_010_00_00;
    localparam logic [12:0] O_WB     = 13'b00_10_00_100_00_00;
    localparam logic [12:0] O_WB_LD  = 13'b00_10_00_101_00_00;
    localparam logic [12:0] O_BR_T   = 13'b00_11_00_000_01_00;
    localparam logic [12:0] O_BR_N   = 13'b00_10_00_000_01_00;
    localparam logic [12:0] O_ILL    = 13'b00_10_00_000_00_10;
    localparam logic [12:0] O_HALT   = 13'b00_00_00_000_00_01;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_cond;
    logic        ir_write, pc_write, pc_src, reg_write, alu_src, mem_to_reg;
    logic [1:0]  alu_op;
    logic        illegal_instr, timeout;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic [12:0] outs;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_controller_if mif ();

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .branch_cond   (branch_cond),
        .mem           (mif),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .alu_src       (alu_src),
        .mem_to_reg    (mem_to_reg),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .timeout       (timeout),
        .state         (state),
        .instr_count   (instr_count)
    );

    assign outs = {mif.imem_req, ir_write, pc_write, pc_src, mif.dmem_read, mif.dmem_write,
                   reg_write, alu_src, mem_to_reg, alu_op, illegal_instr, timeout};

    always #5 clk = ~clk;

    function automatic vec_t vec(input logic run_i, input logic ir_i, input logic dr_i,
                                 input logic [6:0] op_i, input logic bc_i,
                                 input logic [2:0] st_i, input logic [12:0] o_i,
                                 input logic [31:0] cnt_i);
        vec_t v;
        v.run = run_i; v.ir = ir_i; v.dr = dr_i; v.op = op_i; v.bc = bc_i;
        v.st = st_i; v.o = o_i; v.cnt = cnt_i;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        run            = v.run;
        mif.imem_ready = v.ir;
        mif.dmem_ready = v.dr;
        opcode         = v.op;
        branch_cond    = v.bc;
    endtask

    // Reset, release with run=1; returns at the falling edge of the first FETCH cycle.
    task automatic bring_up;
        reset = 1'b0; run = 1'b0; opcode = OP_BAD; branch_cond = 1'b0;
        mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1; run = 1'b1;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; run = 1'b1; opcode = OP_R; branch_cond = 1'b1;
        mif.imem_ready = 1'b1; mif.dmem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({state, outs, instr_count} !== {3'd0, O_NONE, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_hold got st=%0d o=%b cnt=%0d want st=0 o=%b cnt=0",
                     state, outs, instr_count, O_NONE);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_first_edge got st=%0d want st=0", state);
        end
        @(negedge clk);
        vectors++;
        if (state !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_second_edge got st=%0d want st=1", state);
        end
    endtask

    task automatic test_r_i_type;
        vec_t t[9];
        bring_up();
        t[0] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,  0);
        t[1] = vec(1, 1, 0, OP_R,   0, 3'd2, O_NONE, 0);
        t[2] = vec(1, 1, 0, OP_BAD, 0, 3'd3, O_EX_R, 0);
        t[3] = vec(1, 1, 0, OP_BAD, 0, 3'd5, O_WB,   0);
        t[4] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,  1);
        t[5] = vec(1, 1, 0, OP_I,   0, 3'd2, O_NONE, 1);
        t[6] = vec(1, 1, 0, OP_BAD, 0, 3'd3, O_EX_I, 1);
        t[7] = vec(1, 1, 0, OP_BAD, 0, 3'd5, O_WB,   1);
        t[8] = vec(1, 0, 0, OP_BAD, 0, 3'd1, O_F_NR, 2);
        for (int i = 0; i < 9; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL r_i[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        vec_t t[9];
        bring_up();
        t[0] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,    0);
        t[1] = vec(1, 0, 0, OP_LD,  0, 3'd2, O_NONE,   0);
        t[2] = vec(1, 0, 0, OP_BAD, 0, 3'd3, O_EX_LS,  0);
        t[3] = vec(1, 0, 0, OP_BAD, 0, 3'd4, O_MEM_LD, 0);
        t[4] = vec(1, 0, 0, OP_BAD, 0, 3'd4, O_MEM_LD, 0);
        t[5] = vec(1, 0, 0, OP_BAD, 0, 3'd4, O_MEM_LD, 0);
        t[6] = vec(1, 0, 1, OP_BAD, 0, 3'd4, O_MEM_LD, 0);
        t[7] = vec(1, 0, 0, OP_BAD, 0, 3'd5, O_WB_LD,  0);
        t[8] = vec(1, 0, 0, OP_BAD, 0, 3'd1, O_F_NR,   1);
        for (int i = 0; i < 9; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL load[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch;
        vec_t t[7];
        bring_up();
        t[0] = vec(1, 1, 0, OP_BAD, 1, 3'd1, O_F_R,  0);
        t[1] = vec(1, 1, 0, OP_BR,  0, 3'd2, O_NONE, 0);
        t[2] = vec(1, 1, 0, OP_BAD, 1, 3'd3, O_BR_T, 0);
        t[3] = vec(1, 1, 0, OP_BAD, 1, 3'd1, O_F_R,  1);
        t[4] = vec(1, 1, 0, OP_BR,  1, 3'd2, O_NONE, 1);
        t[5] = vec(1, 1, 0, OP_BAD, 0, 3'd3, O_BR_N, 1);
        t[6] = vec(1, 0, 0, OP_BAD, 1, 3'd1, O_F_NR, 2);
        for (int i = 0; i < 7; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL branch[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        vec_t t[4];
        bring_up();
        t[0] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,  0);
        t[1] = vec(1, 0, 0, OP_BAD, 0, 3'd2, O_ILL,  0);
        t[2] = vec(1, 0, 0, OP_BAD, 0, 3'd1, O_F_NR, 1);
        t[3] = vec(1, 0, 0, OP_BAD, 0, 3'd1, O_F_NR, 1);
        for (int i = 0; i < 4; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL illegal[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_timeout;
        vec_t t[19];
        bring_up();
        for (int i = 0; i < 15; i++) t[i] = vec(1, 0, 0, OP_R, 0, 3'd1, O_F_NR, 0);
        t[15] = vec(1, 0, 0, OP_R, 0, 3'd6, O_HALT, 0);
        for (int i = 16; i < 19; i++) t[i] = vec(1, 1, 1, OP_R, 0, 3'd6, O_HALT, 0);
        for (int i = 0; i < 19; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL fetch_to[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
        reset = 1'b0; #1;
        vectors++;
        if ({state, outs} !== {3'd0, O_NONE}) begin
            miscompares++;
            $display("FAIL halt_reset got st=%0d o=%b want st=0 o=%b", state, outs, O_NONE);
        end
    endtask

    // Ready on the last allowed FETCH wait cycle wins; then a STORE times out in MEM.
    task automatic test_ready_wins;
        vec_t t[33];
        bring_up();
        for (int i = 0; i < 14; i++) t[i] = vec(1, 0, 0, OP_BAD, 0, 3'd1, O_F_NR, 0);
        t[14] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,   0);
        t[15] = vec(1, 0, 0, OP_ST,  0, 3'd2, O_NONE,  0);
        t[16] = vec(1, 0, 0, OP_BAD, 0, 3'd3, O_EX_LS, 0);
        for (int i = 17; i < 32; i++) t[i] = vec(1, 0, 0, OP_BAD, 0, 3'd4, O_MEM_ST, 0);
        t[32] = vec(1, 0, 1, OP_BAD, 0, 3'd6, O_HALT, 0);
        for (int i = 0; i < 33; i++) begin
            drive(t[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {t[i].st, t[i].o, t[i].cnt}) begin
                miscompares++;
                $display("FAIL ready_wins[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, t[i].st, t[i].o, t[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_reset_park;
        vec_t a[8];
        vec_t b[8];
        bring_up();
        a[0] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,    0);
        a[1] = vec(1, 0, 0, OP_ST,  0, 3'd2, O_NONE,   0);
        a[2] = vec(1, 0, 0, OP_BAD, 0, 3'd3, O_EX_LS,  0);
        a[3] = vec(1, 0, 1, OP_BAD, 0, 3'd4, O_ST_END, 0);
        a[4] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,    1);
        a[5] = vec(1, 0, 0, OP_ST,  0, 3'd2, O_NONE,   1);
        a[6] = vec(1, 0, 0, OP_BAD, 0, 3'd3, O_EX_LS,  1);
        a[7] = vec(1, 0, 0, OP_BAD, 0, 3'd4, O_MEM_ST, 1);
        for (int i = 0; i < 8; i++) begin
            drive(a[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {a[i].st, a[i].o, a[i].cnt}) begin
                miscompares++;
                $display("FAIL store[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, a[i].st, a[i].o, a[i].cnt);
            end
            if (i < 7) @(negedge clk);
        end
        #2 reset = 1'b0; #1;
        vectors++;
        if ({state, outs, instr_count} !== {3'd0, O_NONE, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_store_reset got st=%0d o=%b cnt=%0d want st=0 o=%b cnt=0",
                     state, outs, instr_count, O_NONE);
        end
        bring_up();
        b[0] = vec(1, 1, 0, OP_BAD, 0, 3'd1, O_F_R,    0);
        b[1] = vec(1, 0, 0, OP_ST,  0, 3'd2, O_NONE,   0);
        b[2] = vec(0, 0, 0, OP_BAD, 0, 3'd3, O_EX_LS,  0);
        b[3] = vec(0, 0, 0, OP_BAD, 0, 3'd4, O_MEM_ST, 0);
        b[4] = vec(0, 0, 1, OP_BAD, 0, 3'd4, O_ST_END, 0);
        b[5] = vec(0, 0, 0, OP_BAD, 0, 3'd0, O_NONE,   1);
        b[6] = vec(0, 1, 1, OP_ST,  1, 3'd0, O_NONE,   1);
        b[7] = vec(0, 1, 1, OP_ST,  1, 3'd0, O_NONE,   1);
        for (int i = 0; i < 8; i++) begin
            drive(b[i]); #1;
            vectors++;
            if ({state, outs, instr_count} !== {b[i].st, b[i].o, b[i].cnt}) begin
                miscompares++;
                $display("FAIL park[%0d] got st=%0d o=%b cnt=%0d want st=%0d o=%b cnt=%0d",
                         i, state, outs, instr_count, b[i].st, b[i].o, b[i].cnt);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_i_type();
        test_load();
        test_branch();
        test_illegal();
        test_fetch_timeout();
        test_ready_wins();
        test_store_reset_park();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
